td4_progmem: RTL and testbench



---
 rtl/td4_progmem.sv | 101 ++++++++++
 tb/tb_td4_progmem.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/td4_progmem.sv
// td4_progmem: serially loaded 16x8 program store for the TD4 core; define TD4_PROG_CSUM_EN to add a csum output.
module td4_progmem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  data,
    input  logic              load_req,
    input  logic              ser_din,
    input  logic              ser_stb,
    output logic              cpu_rst,
    output logic              busy,
    output logic              loaded
`ifdef TD4_PROG_CSUM_EN
    ,
    output logic [WIDTH-1:0]  csum
`endif
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic                loaded_q, loaded_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                start, shift, wr, last_wr;
    logic [WIDTH-1:0]    byte_in;
`ifdef TD4_PROG_CSUM_EN
    logic [WIDTH-1:0]    csum_q, csum_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            loaded_q  <= 1'b0;
            cpu_rst_q <= 1'b1;
`ifdef TD4_PROG_CSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            loaded_q  <= loaded_d;
            cpu_rst_q <= cpu_rst_d;
`ifdef TD4_PROG_CSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // Dropping load_req always wins except that a completing byte is still written.
    always_comb begin
        state_d = state_q == RUN  ? (load_req ? LOAD : RUN) :
                  state_q == LOAD ? (!load_req ? RUN : last_wr ? DONE : LOAD) :
                                    (load_req ? DONE : RUN);
    end

    always_comb begin
        start     = state_q == RUN && load_req;
        shift     = state_q == LOAD && ser_stb;
        wr        = shift && bit_cnt_q == CNT_W'(WIDTH - 1);
        last_wr   = wr && wr_ptr_q == ADDR_W'(DEPTH - 1);
        byte_in   = {shreg_q[WIDTH-2:0], ser_din};
        shreg_d   = start ? '0 : shift ? byte_in : shreg_q;
        bit_cnt_d = start ? '0 : shift ? bit_cnt_q + 1'b1 : bit_cnt_q;
        wr_ptr_d  = start ? '0 : wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        loaded_d  = start ? 1'b0 : last_wr ? 1'b1 : loaded_q;
        cpu_rst_d = state_d != RUN;
        mem_d     = mem_q;
        if (wr)
            mem_d[wr_ptr_q] = byte_in;
`ifdef TD4_PROG_CSUM_EN
        csum_d    = start ? '0 : wr ? csum_q ^ byte_in : csum_q;
`endif
    end

    always_comb begin
        busy    = state_q == LOAD;
        data    = busy ? '0 : mem_q[addr];
        cpu_rst = cpu_rst_q;
        loaded  = loaded_q;
`ifdef TD4_PROG_CSUM_EN
        csum    = csum_q;
`endif
    end
endmodule

// File: tb/tb_td4_progmem.sv
// tb_td4_progmem: scoreboard bench for td4_progmem; define TD4_PROG_CSUM_EN to also check csum.
module tb_td4_progmem;
    logic       clk = 1'b0;
    logic       rst, load_req, ser_din, ser_stb;
    logic [3:0] addr;
    logic [7:0] data;
    logic       cpu_rst, busy, loaded;
`ifdef TD4_PROG_CSUM_EN
    logic [7:0] csum;
`endif

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl [16];
    logic [7:0] csum_m;
    int         wptr;
    int         checks = 0;
    int         errors = 0;

    td4_progmem dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .load_req(load_req),
        .ser_din(ser_din), .ser_stb(ser_stb), .cpu_rst(cpu_rst), .busy(busy),
        .loaded(loaded)
`ifdef TD4_PROG_CSUM_EN
        , .csum(csum)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic c, input logic b, input logic l);
        check({tag, "_cpu_rst"}, 8'(cpu_rst), 8'(c));
        check({tag, "_busy"}, 8'(busy), 8'(b));
        check({tag, "_loaded"}, 8'(loaded), 8'(l));
    endtask

    task automatic check_csum(input string tag);
`ifdef TD4_PROG_CSUM_EN
        check({tag, "_csum"}, csum, csum_m);
`endif
    endtask

    task automatic push_image(input string tag);
        for (int i = 0; i < 16; i++)
            sb.push_back('{$sformatf("%s_mem%0d", tag, i), mdl[i]});
    endtask

    task automatic drain_image();
        exp_t e;
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            if (sb.size() == 0) begin
                check("sb_empty", 8'(sb.size()), 8'd1);
            end else begin
                e = sb.pop_front();
                check(e.tag, data, e.exp);
            end
        end
    endtask

    task automatic start_load();
        load_req = 1'b1;
        tick();
        wptr   = 0;
        csum_m = 8'h00;
    endtask

    task automatic send_bit(input logic b);
        ser_din = b;
        ser_stb = 1'b1;
        tick();
        ser_stb = 1'b0;
        tick($urandom_range(0, 3));
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            send_bit(v[i]);
        mdl[wptr] = v;
        wptr++;
        csum_m ^= v;
    endtask

    task automatic burst(input logic [7:0] v, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            ser_din = v[i];
            ser_stb = 1'b1;
            tick();
        end
        ser_stb = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_req = 1'b0; ser_din = 1'b0; ser_stb = 1'b0; addr = '0;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        csum_m = 8'h00;
        wptr   = 0;
        tick(2);
        check_status("in_rst", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_status("after_rst", 1'b0, 1'b0, 1'b0);
        push_image("idle");
        drain_image();
        check_csum("idle");

        start_load();
        check_status("load_entry", 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            send_byte(8'h30 + 8'(k));
            if (k == 4) begin
                addr = 4'd0;
                #1;
                check("load_data_forced", data, 8'h00);
                check("load_busy", 8'(busy), 8'd1);
            end
        end
        check_status("done", 1'b1, 1'b0, 1'b1);
        check_csum("done");
        for (int i = 0; i < 5; i++) begin
            ser_din = 1'b1;
            ser_stb = i[0];
            tick();
        end
        ser_stb = 1'b0;
        check_status("done_stb", 1'b1, 1'b0, 1'b1);
        load_req = 1'b0;
        tick();
        check_status("run_after_done", 1'b0, 1'b0, 1'b1);
        addr = 4'd5;
        #1;
        check("full_addr5", data, 8'h35);
        for (int i = 0; i < 6; i++) begin
            ser_din = 1'b1;
            ser_stb = ~i[0];
            tick();
        end
        ser_stb = 1'b0;
        push_image("full");
        drain_image();
        check_csum("full");

        start_load();
        send_byte(8'hB1);
        send_byte(8'hB2);
        send_byte(8'hB3);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        load_req = 1'b0;
        tick();
        check_status("abort", 1'b0, 1'b0, 1'b0);
        check_csum("abort");
        push_image("abort");
        drain_image();

        start_load();
        burst(8'hE7, 7);
        load_req = 1'b0;
        tick();
        push_image("b2b7");
        drain_image();
        start_load();
        burst(8'hE7, 8);
        mdl[0] = 8'hE7;
        csum_m = 8'hE7;
        load_req = 1'b0;
        tick();
        check_status("b2b8", 1'b0, 1'b0, 1'b0);
        check_csum("b2b8");
        push_image("b2b8");
        drain_image();

        start_load();
        for (int k = 0; k < 7; k++) send_byte(8'h50 + 8'(k));
        rst = 1'b1;
        load_req = 1'b0;
        tick();
        check_status("midrst", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        csum_m = 8'h00;
        check_status("midrst_run", 1'b0, 1'b0, 1'b0);
        check_csum("midrst");
        push_image("midrst");
        drain_image();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
